id_ex_stage: RTL and testbench

//  Decode-to-execute pipeline register for the 5-stage MIPS core. Sits between the decode stage and the execute stage.

---
 rtl/id_ex_stage_pkg.sv | 40 ++++
 rtl/id_ex_stage_if.sv | 41 ++++
 rtl/id_ex_stage_hazard.sv | 78 +++++++
 rtl/id_ex_stage.sv | 113 +++++++++++
 tb/tb_id_ex_stage.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared encodings for the decode-to-execute register.
// Forwarding build option: define ID_EX_FWD_EN.
package id_ex_stage_pkg;

    localparam int CTRL_W = 11;

    localparam int CTRL_REGDST = 10;
    localparam int CTRL_ALUSRC = 9;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEM2REG = 7;
    localparam int CTRL_MEMREAD = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_BRANCH = 4;
    localparam int CTRL_JUMP = 3;
    localparam int CTRL_OP = 0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_e;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       rd1;
        logic [31:0]       rd2;
        logic [31:0]       imm;
        logic [31:0]       pcp4;
        logic [4:0]        wn;
        fwd_e              fwd_a;
        fwd_e              fwd_b;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs and execute-side outputs of the ID/EX register.
// master = decode/execute neighbours, slave = the pipeline register.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic              id_valid;
    logic [31:0]       id_ins;
    logic [31:0]       id_rd1;
    logic [31:0]       id_rd2;
    logic [31:0]       id_imm;
    logic [31:0]       id_pcp4;
    logic [CTRL_W-1:0] id_ctrl;

    logic              stall;
    logic              ex_valid;
    logic [31:0]       ex_rd1;
    logic [31:0]       ex_rd2;
    logic [31:0]       ex_imm;
    logic [31:0]       ex_pcp4;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_wn;
    logic [1:0]        ex_fwd_a;
    logic [1:0]        ex_fwd_b;

    modport master (
        output id_valid, id_ins, id_rd1, id_rd2,
        output id_imm, id_pcp4, id_ctrl,
        input  stall, ex_valid, ex_rd1, ex_rd2,
        input  ex_imm, ex_pcp4, ex_ctrl, ex_wn,
        input  ex_fwd_a, ex_fwd_b
    );

    modport slave (
        input  id_valid, id_ins, id_rd1, id_rd2,
        input  id_imm, id_pcp4, id_ctrl,
        output stall, ex_valid, ex_rd1, ex_rd2,
        output ex_imm, ex_pcp4, ex_ctrl, ex_wn,
        output ex_fwd_a, ex_fwd_b
    );

endinterface

// File: rtl/id_ex_stage_hazard.sv
// id_ex_hazard: source-use, RAW match, stall, bypass and forward-select logic.
// ID_EX_FWD_EN selects load-use-only stalling with EX forwarding.
module id_ex_hazard
    import id_ex_stage_pkg::*;
(
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       alusrc,
    input  logic       memwrite,
    input  logic       ex_valid,
    input  logic       ex_regwr,
    input  logic       ex_memrd,
    input  logic [4:0] ex_wn,
    input  logic       mem_valid,
    input  logic       mem_regwr,
    input  logic [4:0] mem_wn,
    input  logic       wb_valid,
    input  logic       wb_regwr,
    input  logic [4:0] wb_wn,
    input  logic       flush,
    output logic       stall,
    output logic       byp_a,
    output logic       byp_b,
    output fwd_e       fwd_a,
    output fwd_e       fwd_b
);

    logic use_a, use_b;
    logic ex_hit_a, ex_hit_b;
    logic mem_hit_a, mem_hit_b;
    logic hazard;

    assign use_a = id_valid && (rs != 5'd0);
    assign use_b = id_valid && (!alusrc || memwrite) && (rt != 5'd0);

    assign ex_hit_a = ex_valid && ex_regwr && (ex_wn == rs);
    assign ex_hit_b = ex_valid && ex_regwr && (ex_wn == rt);
    assign mem_hit_a = mem_valid && mem_regwr && (mem_wn == rs);
    assign mem_hit_b = mem_valid && mem_regwr && (mem_wn == rt);

    // WB writes the regfile this same cycle, so its data is grabbed directly
    assign byp_a = wb_valid && wb_regwr && (wb_wn == rs) && (rs != 5'd0);
    assign byp_b = wb_valid && wb_regwr && (wb_wn == rt) && (rt != 5'd0);

`ifdef ID_EX_FWD_EN
    logic ld_a, ld_b;

    assign ld_a = ex_valid && ex_memrd && (ex_wn == rs);
    assign ld_b = ex_valid && ex_memrd && (ex_wn == rt);
    assign hazard = (use_a && ld_a) || (use_b && ld_b);

    // The producer now in EX sits in MEM when this slot executes
    always_comb begin
        fwd_a = FWD_RF;
        if (use_a && ex_hit_a) fwd_a = FWD_MEM;
        else if (use_a && mem_hit_a) fwd_a = FWD_WB;
    end

    always_comb begin
        fwd_b = FWD_RF;
        if (use_b && ex_hit_b) fwd_b = FWD_MEM;
        else if (use_b && mem_hit_b) fwd_b = FWD_WB;
    end
`else
    logic unused_memrd;

    assign unused_memrd = ex_memrd;
    assign hazard = (use_a && (ex_hit_a || mem_hit_a)) ||
                    (use_b && (ex_hit_b || mem_hit_b));
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    assign stall = rst_n && !flush && hazard;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with hazard stall, bubble and flush.
// Define ID_EX_FWD_EN for load-use-only stalls and registered forward selects.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    id_ex_stage_if.slave           pipe,
    input  logic                   mem_valid,
    input  logic                   mem_regwr,
    input  logic [4:0]             mem_wn,
    input  logic                   wb_valid,
    input  logic                   wb_regwr,
    input  logic [4:0]             wb_wn,
    input  logic [31:0]            wb_wd,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [4:0] rs, rt, rd;
    logic       stall, byp_a, byp_b;
    fwd_e       fwd_a, fwd_b;
    id_ex_t     ex_q, ex_d;
    state_e     state;
    logic       unused_ins;

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    assign rs = pipe.id_ins[25:21];
    assign rt = pipe.id_ins[20:16];
    assign rd = pipe.id_ins[15:11];
    assign unused_ins = ^{pipe.id_ins[31:26], pipe.id_ins[10:0]};

    id_ex_hazard u_hazard (
        .rst_n    (rst_n),
        .id_valid (pipe.id_valid),
        .rs       (rs),
        .rt       (rt),
        .alusrc   (pipe.id_ctrl[CTRL_ALUSRC]),
        .memwrite (pipe.id_ctrl[CTRL_MEMWRITE]),
        .ex_valid (ex_q.valid),
        .ex_regwr (ex_q.ctrl[CTRL_REGWRITE]),
        .ex_memrd (ex_q.ctrl[CTRL_MEMREAD]),
        .ex_wn    (ex_q.wn),
        .mem_valid(mem_valid),
        .mem_regwr(mem_regwr),
        .mem_wn   (mem_wn),
        .wb_valid (wb_valid),
        .wb_regwr (wb_regwr),
        .wb_wn    (wb_wn),
        .flush    (flush),
        .stall    (stall),
        .byp_a    (byp_a),
        .byp_b    (byp_b),
        .fwd_a    (fwd_a),
        .fwd_b    (fwd_b)
    );

    // Stall and flush both load an all-zero bubble
    always_comb begin
        ex_d = '0;
        if (!(stall || flush)) begin
            ex_d.valid = pipe.id_valid;
            ex_d.ctrl  = pipe.id_valid ? pipe.id_ctrl : '0;
            ex_d.rd1   = byp_a ? wb_wd : pipe.id_rd1;
            ex_d.rd2   = byp_b ? wb_wd : pipe.id_rd2;
            ex_d.imm   = pipe.id_imm;
            ex_d.pcp4  = pipe.id_pcp4;
            ex_d.wn    = pipe.id_ctrl[CTRL_REGDST] ? rd : rt;
            ex_d.fwd_a = fwd_a;
            ex_d.fwd_b = fwd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q      <= '0;
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            ex_q <= ex_d;
            unique case (state)
                RUN: begin
                    if (stall) begin
                        state <= STALL;
                        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
                    end
                end
                STALL: begin
                    if (!stall) begin
                        state <= RUN;
                    end else if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign pipe.stall    = stall;
    assign pipe.ex_valid = ex_q.valid;
    assign pipe.ex_ctrl  = ex_q.ctrl;
    assign pipe.ex_rd1   = ex_q.rd1;
    assign pipe.ex_rd2   = ex_q.rd2;
    assign pipe.ex_imm   = ex_q.imm;
    assign pipe.ex_pcp4  = ex_q.pcp4;
    assign pipe.ex_wn    = ex_q.wn;
    assign pipe.ex_fwd_a = ex_q.fwd_a;
    assign pipe.ex_fwd_b = ex_q.fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage with a behavioural model.
// Expectations follow ID_EX_FWD_EN the same way the DUT build does.
module tb_id_ex_stage;

    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int B_REGDST = 10;
    localparam int B_ALUSRC = 9;
    localparam int B_REGWR = 8;
    localparam int B_MEMRD = 6;
    localparam int B_MEMWR = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_valid, mem_regwr;
    logic [4:0]    mem_wn;
    logic          wb_valid, wb_regwr;
    logic [4:0]    wb_wn;
    logic [31:0]   wb_wd;
    logic          flush;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage_if bus();

    id_ex_stage #(.STALL_CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pipe     (bus),
        .mem_valid(mem_valid),
        .mem_regwr(mem_regwr),
        .mem_wn   (mem_wn),
        .wb_valid (wb_valid),
        .wb_regwr (wb_regwr),
        .wb_wn    (wb_wn),
        .wb_wd    (wb_wd),
        .flush    (flush),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        bit          valid;
        logic [10:0] ctrl;
        logic [31:0] rd1, rd2, imm, pcp4;
        logic [4:0]  wn;
        logic [1:0]  fa, fb;
        int          cnt;
    } exp_t;

    exp_t mex;
    exp_t me;
    exp_t q[$];
    int   mcnt = 0;
    int   tests = 0;
    int   fails = 0;
    bit   auto_pipe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit used_b();
        return bus.id_valid && (!bus.id_ctrl[B_ALUSRC] || bus.id_ctrl[B_MEMWR]);
    endfunction

    // Hazard from the rules: any used nonzero source with a pending producer
    function automatic bit model_hazard();
        logic [4:0]  srcs[$];
        logic [31:0] ins;
        ins = bus.id_ins;
        if (bus.id_valid && ins[25:21] != 0) srcs.push_back(ins[25:21]);
        if (used_b() && ins[20:16] != 0) srcs.push_back(ins[20:16]);
        foreach (srcs[i]) begin
`ifdef ID_EX_FWD_EN
            if (mex.valid && mex.ctrl[B_MEMRD] && mex.wn == srcs[i]) return 1'b1;
`else
            if (mex.valid && mex.ctrl[B_REGWR] && mex.wn == srcs[i]) return 1'b1;
            if (mem_valid && mem_regwr && mem_wn == srcs[i]) return 1'b1;
`endif
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] s, input bit used);
        logic [1:0] r;
        r = 2'b00;
        if (used && s != 0) begin
`ifdef ID_EX_FWD_EN
            if (mex.valid && mex.ctrl[B_REGWR] && mex.wn == s) r = 2'b01;
            else if (mem_valid && mem_regwr && mem_wn == s) r = 2'b10;
`endif
        end
        return r;
    endfunction

    function automatic logic [31:0] byp(input logic [4:0] s, input logic [31:0] rf);
        return (wb_valid && wb_regwr && wb_wn == s && s != 0) ? wb_wd : rf;
    endfunction

    task automatic model_step(input bit s);
        exp_t n;
        logic [31:0] ins;
        ins = bus.id_ins;
        n = '{default: 0};
        if (!rst_n) begin
            mcnt = 0;
        end else begin
            if (s && mcnt < CMAX) mcnt++;
            if (!(s || flush)) begin
                n.valid = bus.id_valid;
                n.ctrl  = bus.id_valid ? bus.id_ctrl : 11'd0;
                n.rd1   = byp(ins[25:21], bus.id_rd1);
                n.rd2   = byp(ins[20:16], bus.id_rd2);
                n.imm   = bus.id_imm;
                n.pcp4  = bus.id_pcp4;
                n.wn    = bus.id_ctrl[B_REGDST] ? ins[15:11] : ins[20:16];
                n.fa    = fsel(ins[25:21], bus.id_valid);
                n.fb    = fsel(ins[20:16], used_b());
            end
        end
        n.cnt = mcnt;
        mex = n;
    endtask

    // Called at a negedge with inputs applied; returns the DUT stall seen
    task automatic tick(output bit st);
        bit   es;
        exp_t prev;
        #1;
        st = bus.stall;
        es = rst_n && !flush && model_hazard();
        chk("stall", {31'd0, st}, {31'd0, es});
        prev = mex;
        model_step(es);
        q.push_back(mex);
        @(negedge clk);
        if (auto_pipe) begin
            wb_valid  = mem_valid;
            wb_regwr  = mem_regwr;
            wb_wn     = mem_wn;
            wb_wd     = $urandom;
            mem_valid = prev.valid;
            mem_regwr = prev.ctrl[B_REGWR];
            mem_wn    = prev.wn;
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, me.valid});
            chk("ex_ctrl", {21'd0, bus.ex_ctrl}, {21'd0, me.ctrl});
            chk("ex_fwd_a", {30'd0, bus.ex_fwd_a}, {30'd0, me.fa});
            chk("ex_fwd_b", {30'd0, bus.ex_fwd_b}, {30'd0, me.fb});
            chk("stall_cnt", {30'd0, stall_cnt}, me.cnt);
            if (me.valid) begin
                chk("ex_rd1", bus.ex_rd1, me.rd1);
                chk("ex_rd2", bus.ex_rd2, me.rd2);
                chk("ex_imm", bus.ex_imm, me.imm);
                chk("ex_pcp4", bus.ex_pcp4, me.pcp4);
                chk("ex_wn", {27'd0, bus.ex_wn}, {27'd0, me.wn});
            end
        end
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic set_id(input logic [31:0] ins, input logic [10:0] c);
        bus.id_valid = 1'b1;
        bus.id_ins   = ins;
        bus.id_ctrl  = c;
        bus.id_rd1   = $urandom;
        bus.id_rd2   = $urandom;
        bus.id_imm   = $urandom;
        bus.id_pcp4  = $urandom;
    endtask

    task automatic rand_id();
        logic [31:0] ins;
        ins = $urandom;
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
        set_id(ins, 11'($urandom));
        bus.id_valid = ($urandom_range(0, 7) != 0);
    endtask

    task automatic idle(input int n);
        bit st;
        bus.id_valid = 1'b0;
        repeat (n) tick(st);
    endtask

    task automatic run_pair(input string nm, input logic [31:0] i1, input logic [10:0] c1,
                            input logic [31:0] i2, input logic [10:0] c2, input int exp_n);
        bit st;
        int n;
        n = 0;
        set_id(i1, c1);
        tick(st);
        set_id(i2, c2);
        for (int k = 0; k < 6; k++) begin
            tick(st);
            if (!st) break;
            n++;
        end
        chk({nm, "_stalls"}, n, exp_n);
        idle(3);
    endtask

    localparam logic [10:0] C_ADD  = 11'h502;
    localparam logic [10:0] C_SUB  = 11'h506;
    localparam logic [10:0] C_LW   = 11'h3C0;
    localparam logic [10:0] C_ADDI = 11'h302;

`ifdef ID_EX_FWD_EN
    localparam int N_ALU = 0;
    localparam int N_LU  = 1;
`else
    localparam int N_ALU = 2;
    localparam int N_LU  = 2;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit st;
        logic [31:0] lw8, add10;
        lw8   = itype(6'h23, 5'd9, 5'd8, 16'd0);
        add10 = rtype(5'd8, 5'd11, 5'd10);
        rst_n = 1'b0;
        flush = 1'b0;
        mem_valid = 1'b0; mem_regwr = 1'b0; mem_wn = 5'd0;
        wb_valid = 1'b0; wb_regwr = 1'b0; wb_wn = 5'd0; wb_wd = 32'd0;
        auto_pipe = 1'b1;
        set_id(rtype(5'd1, 5'd2, 5'd3), C_ADD);
        @(negedge clk);

        tick(st);
        tick(st);
        chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_ex_ctrl", {21'd0, bus.ex_ctrl}, 32'd0);
        chk("rst_stall_cnt", {30'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;
        idle(3);

        run_pair("alu_b2b", rtype(5'd1, 5'd2, 5'd8), C_ADD, rtype(5'd8, 5'd8, 5'd12), C_SUB, N_ALU);
        run_pair("load_use", lw8, C_LW, add10, C_ADD, N_LU);
        run_pair("reg0", itype(6'h08, 5'd0, 5'd0, 16'd5), C_ADDI, rtype(5'd0, 5'd0, 5'd1), C_ADD, 0);

        set_id(lw8, C_LW);
        tick(st);
        set_id(add10, C_ADD);
        tick(st);
        chk("flush_pre_stall", {31'd0, st}, 32'd1);
        flush = 1'b1;
        tick(st);
        chk("flush_stall", {31'd0, st}, 32'd0);
        flush = 1'b0;
        idle(3);

        set_id(lw8, C_LW);
        tick(st);
        set_id(add10, C_ADD);
        tick(st);
        rst_n = 1'b0;
        tick(st);
        chk("rst_mid_stall", {31'd0, st}, 32'd0);
        rst_n = 1'b1;
        idle(3);
        chk("rst_mid_valid", {31'd0, bus.ex_valid}, 32'd0);

        repeat (5) run_pair("sat", lw8, C_LW, add10, C_ADD, N_LU);
        chk("cnt_sat", {30'd0, stall_cnt}, CMAX);

        auto_pipe = 1'b0;
        st = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!st) rand_id();
            mem_valid = 1'($urandom_range(0, 1));
            mem_regwr = 1'($urandom_range(0, 1));
            mem_wn    = 5'($urandom_range(0, 7));
            wb_valid  = 1'($urandom_range(0, 1));
            wb_regwr  = 1'($urandom_range(0, 1));
            wb_wn     = 5'($urandom_range(0, 7));
            wb_wd     = $urandom;
            flush     = ($urandom_range(0, 9) == 0);
            rst_n     = ($urandom_range(0, 63) != 0);
            tick(st);
        end
        rst_n = 1'b1;
        flush = 1'b0;
        idle(2);
        chk("queue_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
